// File: rtl/hart_issue_sched.sv
// hart_issue_sched: per-hart run state and round-robin pick of the next hart to fetch.
// Define HART_SCHED_PERF_EN to add per-hart 32-bit issue counters on issue_cnt.
module hart_issue_sched #(
    parameter int HART_NUM  = 4,
    parameter int HART_ID_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 cache_miss,
    input  logic [HART_ID_W-1:0] cm_hart_id,
    input  logic                 refill_done,
    input  logic [HART_ID_W-1:0] rf_hart_id,
    input  logic                 hstart,
    input  logic [HART_ID_W-1:0] hs_id,
    input  logic                 hkill,
    input  logic [HART_ID_W-1:0] hk_id,
    output logic [HART_ID_W-1:0] hart_id,
    output logic                 issue_en,
    output logic                 hs_idle,
    output logic [HART_NUM-1:0]  hart_idle
`ifdef HART_SCHED_PERF_EN
    ,
    output logic [HART_NUM*32-1:0] issue_cnt
`endif
);
    typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, PEND = 2'b10} hstate_t;

    hstate_t [HART_NUM-1:0] state, state_nxt;
    logic [HART_NUM-1:0]  kill_hit, miss_hit, refill_hit, start_hit, eligible;
    logic [HART_ID_W-1:0] ptr, winner, idx;
    logic                 any;

    always_comb begin
        state_nxt  = state;
        kill_hit   = '0;
        miss_hit   = '0;
        refill_hit = '0;
        start_hit  = '0;
        eligible   = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            kill_hit[h]   = hkill && hk_id == HART_ID_W'(h);
            miss_hit[h]   = cache_miss && cm_hart_id == HART_ID_W'(h);
            refill_hit[h] = refill_done && rf_hart_id == HART_ID_W'(h);
            start_hit[h]  = hstart && hs_id == HART_ID_W'(h);
            if (kill_hit[h] && state[h] != IDLE) state_nxt[h] = IDLE;
            else if (miss_hit[h] && state[h] == ACTIVE) state_nxt[h] = PEND;
            else if (refill_hit[h] && state[h] == PEND) state_nxt[h] = ACTIVE;
            else if (start_hit[h] && state[h] == IDLE) state_nxt[h] = ACTIVE;
            eligible[h] = state[h] == ACTIVE && !miss_hit[h] && !kill_hit[h];
        end
    end

    // Scan from farthest to nearest so the hart right after ptr wins; i==HART_NUM wraps to ptr itself.
    always_comb begin
        winner = ptr;
        idx    = ptr;
        any    = |eligible;
        for (int i = HART_NUM; i >= 1; i--) begin
            idx = ptr + HART_ID_W'(i);
            if (eligible[idx]) winner = idx;
        end
    end

    assign hs_idle = state[hs_id] == IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int h = 0; h < HART_NUM; h++) begin
                state[h]     <= (h == 0) ? ACTIVE : IDLE;
                hart_idle[h] <= h != 0;
            end
            hart_id  <= '0;
            issue_en <= 1'b1;
            ptr      <= HART_ID_W'(HART_NUM - 1);
        end else begin
            state <= state_nxt;
            for (int h = 0; h < HART_NUM; h++) hart_idle[h] <= state_nxt[h] == IDLE;
            if (!stall) begin
                issue_en <= any;
                if (any) begin
                    hart_id <= winner;
                    ptr     <= winner;
                end
            end
        end
    end

`ifdef HART_SCHED_PERF_EN
    always_ff @(posedge clk) begin
        if (!reset) issue_cnt <= '0;
        else if (issue_en && !stall) issue_cnt[hart_id*32 +: 32] <= issue_cnt[hart_id*32 +: 32] + 32'd1;
    end
`endif
endmodule

// File: tb/tb_hart_issue_sched.sv
// tb_hart_issue_sched: directed stimulus against a reference model; expected outputs
// are queued when each cycle is driven and checked after the following clock edge.
module tb_hart_issue_sched;
    logic       clk = 1'b0, reset = 1'b0, stall = 1'b0;
    logic       cache_miss = 1'b0, refill_done = 1'b0, hstart = 1'b0, hkill = 1'b0;
    logic [1:0] cm_hart_id = '0, rf_hart_id = '0, hs_id = '0, hk_id = '0;
    logic [1:0] hart_id;
    logic       issue_en, hs_idle;
    logic [3:0] hart_idle;

    hart_issue_sched dut (
        .clk(clk), .reset(reset), .stall(stall),
        .cache_miss(cache_miss), .cm_hart_id(cm_hart_id),
        .refill_done(refill_done), .rf_hart_id(rf_hart_id),
        .hstart(hstart), .hs_id(hs_id), .hkill(hkill), .hk_id(hk_id),
        .hart_id(hart_id), .issue_en(issue_en), .hs_idle(hs_idle), .hart_idle(hart_idle)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] hid;
        logic       en;
        logic [3:0] idle;
    } exp_t;
    exp_t q[$];

    int errors = 0, checks = 0;
    // Model: 0 = IDLE, 1 = ACTIVE, 2 = PEND
    int st[4];
    int mptr, mhid;
    bit men;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] idle_mask();
        logic [3:0] m;
        for (int h = 0; h < 4; h++) m[h] = st[h] == 0;
        return m;
    endfunction

    task automatic model_reset();
        st = '{1, 0, 0, 0};
        mptr = 3;
        mhid = 0;
        men = 1'b1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b0;
        {stall, cache_miss, refill_done, hstart, hkill} = '0;
        repeat (n) @(posedge clk);
        #1;
        model_reset();
        chk("rst_hart_id", 32'(hart_id), 32'd0);
        chk("rst_issue_en", 32'(issue_en), 32'd1);
        chk("rst_hart_idle", 32'(hart_idle), 32'b1110);
    endtask

    task automatic step(input bit s, input bit cm, input int cmid, input bit rf, input int rfid,
                        input bit hs, input int hsid, input bit hk, input int hkid);
        exp_t e;
        int w;
        bit found;
        @(negedge clk);
        reset = 1'b1;
        stall = s;
        cache_miss = cm;  cm_hart_id = 2'(cmid);
        refill_done = rf; rf_hart_id = 2'(rfid);
        hstart = hs;      hs_id = 2'(hsid);
        hkill = hk;       hk_id = 2'(hkid);
        #1;
        chk("hs_idle", 32'(hs_idle), 32'(st[hsid] == 0));
        found = 1'b0;
        w = 0;
        for (int k = 1; k <= 4; k++) begin
            int h;
            h = (mptr + k) % 4;
            if (!found && st[h] == 1 && !(cm && cmid == h) && !(hk && hkid == h)) begin
                found = 1'b1;
                w = h;
            end
        end
        if (!s) begin
            men = found;
            if (found) begin
                mhid = w;
                mptr = w;
            end
        end
        for (int h = 0; h < 4; h++) begin
            if (hk && hkid == h && st[h] != 0) st[h] = 0;
            else if (cm && cmid == h && st[h] == 1) st[h] = 2;
            else if (rf && rfid == h && st[h] == 2) st[h] = 1;
            else if (hs && hsid == h && st[h] == 0) st[h] = 1;
        end
        e.hid = 2'(mhid);
        e.en = men;
        e.idle = idle_mask();
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("hart_id", 32'(hart_id), 32'(e.hid));
        chk("issue_en", 32'(issue_en), 32'(e.en));
        chk("hart_idle", 32'(hart_idle), 32'(e.idle));
    endtask

    task automatic idle_steps(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        model_reset();
        do_reset(2);
        idle_steps(3);
        chk("lone_hart0", 32'(hart_id), 32'd0);
        // Start harts 1..3 in successive cycles, then watch the RR wrap.
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 0, 0);
        step(0, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("all_active_idle", 32'(hart_idle), 32'b0000);
        idle_steps(6);
        // Start on an already ACTIVE hart is ignored.
        step(0, 0, 0, 0, 0, 1, 3, 0, 0);
        chk("hs_idle_active", 32'(hs_idle), 32'd0);
        // Hart 2 misses, is skipped, then refills.
        step(0, 1, 2, 0, 0, 0, 0, 0, 0);
        idle_steps(4);
        step(0, 0, 0, 1, 2, 0, 0, 0, 0);
        idle_steps(4);
        // Kill and start on hart 1 together: kill wins. Miss on 3 in the same cycle also applies.
        step(0, 1, 3, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 3, 0, 0, 1, 2);
        step(0, 0, 0, 0, 0, 0, 0, 1, 3);
        idle_steps(2);
        // Only hart 0 left: its miss idles the issue slot until refill.
        step(0, 1, 0, 0, 0, 0, 0, 0, 0);
        chk("no_elig_en", 32'(issue_en), 32'd0);
        idle_steps(2);
        step(0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle_steps(2);
        chk("refill_hart0", 32'(hart_id), 32'd0);
        // Stall while states change; outputs and ptr hold.
        step(0, 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 2, 0, 0);
        step(1, 0, 0, 0, 0, 1, 3, 0, 0);
        step(1, 1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 0, 0, 0);
        idle_steps(5);
        // Reset while hart 1 is pending: its later refill must not revive it.
        step(0, 1, 1, 0, 0, 0, 0, 0, 0);
        do_reset(1);
        step(0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle_steps(2);
        chk("post_rst_idle", 32'(hart_idle), 32'b1110);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
